// File: rtl/bcd_pkg.sv
// Shared types for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
// Combinational, zero latency; no handshake.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    bcd_digit_t d;

    assign d    = din;
    assign dout = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// W-bit binary to DIGITS-digit BCD, one bit per clock (shift-add-3), sticky overflow.
// Latency W+1 cycles from capture to out_valid; initiation interval W+2.
// Backpressure: result held in DONE until out_ready; no input accepted outside IDLE.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   bin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0]  bcd,
    output logic                           overflow
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(W + 1);

    bcd_state_e      state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sreg, sreg_nxt;
    logic [BW-1:0]   acc, acc_adj, acc_nxt;
    logic            ovf_acc, ovf_nxt;
    logic [BW-1:0]   bcd_q;
    logic            ovf_q;
    logic            last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The bit leaving the top digit is worth 10^DIGITS; it only feeds overflow.
    assign {acc_nxt, sreg_nxt} = {acc_adj, sreg} << 1;
    assign ovf_nxt             = ovf_acc | acc_adj[BW-1];
    assign last                = (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg    <= bin;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CW'(W);
                    end
                end
                SHIFT: begin
                    sreg    <= sreg_nxt;
                    acc     <= acc_nxt;
                    ovf_acc <= ovf_nxt;
                    cnt     <= cnt - CW'(1);
                    // Outputs only change on the final shift, so they hold across captures.
                    if (last) begin
                        bcd_q <= acc_nxt;
                        ovf_q <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating with rst keeps the converter from advertising readiness during reset.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign bcd       = bcd_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomised checks of bin2bcd_seq in four parameterisations.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // A: W=8, DIGITS=3
    logic        iv_a = 1'b0, ir_a, ov_a, or_a = 1'b1, of_a;
    logic [7:0]  bin_a = '0;
    logic [11:0] bcd_a;
    // B: W=8, DIGITS=2
    logic        iv_b = 1'b0, ir_b, ov_b, or_b = 1'b1, of_b;
    logic [7:0]  bin_b = '0;
    logic [7:0]  bcd_b;
    // C: W=4, DIGITS=1
    logic        iv_c = 1'b0, ir_c, ov_c, or_c = 1'b1, of_c;
    logic [3:0]  bin_c = '0;
    logic [3:0]  bcd_c;
    // D: W=16, DIGITS=5
    logic        iv_d = 1'b0, ir_d, ov_d, or_d = 1'b1, of_d;
    logic [15:0] bin_d = '0;
    logic [19:0] bcd_d;

    bin2bcd_seq #(.W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .bin(bin_a),
        .out_valid(ov_a), .out_ready(or_a), .bcd(bcd_a), .overflow(of_a));
    bin2bcd_seq #(.W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .bin(bin_b),
        .out_valid(ov_b), .out_ready(or_b), .bcd(bcd_b), .overflow(of_b));
    bin2bcd_seq #(.W(4), .DIGITS(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .bin(bin_c),
        .out_valid(ov_c), .out_ready(or_c), .bcd(bcd_c), .overflow(of_c));
    bin2bcd_seq #(.W(16), .DIGITS(5)) u_d (
        .clk(clk), .rst(rst), .in_valid(iv_d), .in_ready(ir_d), .bin(bin_d),
        .out_valid(ov_d), .out_ready(or_d), .bcd(bcd_d), .overflow(of_d));

    function automatic logic [19:0] ref_bcd5(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v % 100000;
        for (int k = 0; k < 5; k++) begin
            r[k*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ir_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", ir_a); end
        checks++;
        if ({ov_a, of_a, bcd_a} !== 14'h0) begin
            errors++; $display("FAIL reset_outputs: ov=%b of=%b bcd=%h want 0 0 000", ov_a, of_a, bcd_a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ir_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %b want 1", ir_a); end
        checks++;
        if ({ov_a, of_a, bcd_a} !== 14'h0) begin
            errors++; $display("FAIL post_reset_outputs: ov=%b of=%b bcd=%h want 0 0 000", ov_a, of_a, bcd_a);
        end
    endtask

    task automatic test_main_255();
        or_a = 1'b1;
        bin_a = 8'd255;
        iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        checks++;
        if (ir_a !== 1'b0) begin errors++; $display("FAIL main_in_ready_fall: got %b want 0", ir_a); end
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ov_a !== (k == 8)) begin
                errors++; $display("FAIL main_out_valid_edge%0d: got %b want %b", k, ov_a, (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (bcd_a !== 12'h255 || of_a !== 1'b0) begin
                    errors++; $display("FAIL main_255: bcd=%h of=%b want 255 0", bcd_a, of_a);
                end
            end
        end
        checks++;
        if (ir_a !== 1'b1) begin errors++; $display("FAIL main_in_ready_rise: got %b want 1", ir_a); end
    endtask

    task automatic test_digits2();
        logic [7:0] vin  [2] = '{8'd123, 8'd99};
        logic [7:0] vbcd [2] = '{8'h23, 8'h99};
        logic       vof  [2] = '{1'b1, 1'b0};
        int n;
        for (int i = 0; i < 2; i++) begin
            bin_b = vin[i];
            iv_b = 1'b1;
            @(posedge clk); #1;
            iv_b = 1'b0;
            n = 0;
            while (!ov_b && n < 20) begin @(posedge clk); #1; n++; end
            checks++;
            if (!ov_b) begin
                errors++; $display("FAIL digits2_timeout: out_valid=%b want 1", ov_b);
            end else if (bcd_b !== vbcd[i] || of_b !== vof[i]) begin
                errors++; $display("FAIL digits2_%0d: bcd=%h of=%b want %h %b", vin[i], bcd_b, of_b, vbcd[i], vof[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_legacy();
        logic [3:0] eb;
        logic       eo;
        int n;
        for (int i = 0; i < 16; i++) begin
            eb = (i < 10) ? 4'(i) : 4'(i - 10);
            eo = (i >= 10);
            bin_c = 4'(i);
            iv_c = 1'b1;
            @(posedge clk); #1;
            iv_c = 1'b0;
            n = 0;
            while (!ov_c && n < 12) begin @(posedge clk); #1; n++; end
            checks++;
            if (!ov_c) begin
                errors++; $display("FAIL legacy_timeout_%0d: out_valid=%b want 1", i, ov_c);
            end else if (bcd_c !== eb || of_c !== eo) begin
                errors++; $display("FAIL legacy_%0d: bcd=%h of=%b want %h %b", i, bcd_c, of_c, eb, eo);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int n;
        or_a = 1'b0;
        bin_a = 8'd7;
        iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        n = 0;
        while (!ov_a && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!ov_a || bcd_a !== 12'h007) begin
            errors++; $display("FAIL bp_result: ov=%b bcd=%h want 1 007", ov_a, bcd_a);
        end
        bin_a = 8'd200;
        iv_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ov_a !== 1'b1 || ir_a !== 1'b0 || bcd_a !== 12'h007) begin
                errors++; $display("FAIL bp_hold_%0d: ov=%b ir=%b bcd=%h want 1 0 007", k, ov_a, ir_a, bcd_a);
            end
        end
        or_a = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1) begin
            errors++; $display("FAIL bp_release: ov=%b ir=%b want 0 1", ov_a, ir_a);
        end
        @(posedge clk); #1;
        iv_a = 1'b0;
        checks++;
        if (ir_a !== 1'b0 || bcd_a !== 12'h007) begin
            errors++; $display("FAIL bp_capture_200: ir=%b bcd=%h want 0 007", ir_a, bcd_a);
        end
        n = 0;
        while (!ov_a && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!ov_a || bcd_a !== 12'h200 || of_a !== 1'b0) begin
            errors++; $display("FAIL bp_result_200: ov=%b bcd=%h of=%b want 1 200 0", ov_a, bcd_a, of_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        bin_a = 8'd255;
        iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ir_a !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_low: got %b want 0", ir_a); end
        rst = 1'b0;
        #1;
        checks++;
        if (ov_a !== 1'b0 || bcd_a !== 12'h000 || of_a !== 1'b0 || ir_a !== 1'b1) begin
            errors++; $display("FAIL midrst_state: ov=%b bcd=%h of=%b ir=%b want 0 000 0 1", ov_a, bcd_a, of_a, ir_a);
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ov_a) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_no_output: got out_valid=1 want 0"); end
        bin_a = 8'd42;
        iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        n = 0;
        while (!ov_a && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!ov_a || bcd_a !== 12'h042 || of_a !== 1'b0) begin
            errors++; $display("FAIL midrst_42: ov=%b bcd=%h of=%b want 1 042 0", ov_a, bcd_a, of_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] expq [$];
        int sent, got;
        sent = 0;
        got  = 0;
        fork
            begin : producer
                int budget;
                bit ok;
                budget = 0;
                while (sent < 1000 && budget < 60000) begin
                    iv_d = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; budget++; end
                    bin_d = 16'($urandom);
                    iv_d = 1'b1;
                    ok = 1'b0;
                    while (!ok && budget < 60000) begin
                        ok = ir_d;
                        @(posedge clk); #1;
                        budget++;
                    end
                    if (ok) begin expq.push_back(bin_d); sent++; end
                end
                iv_d = 1'b0;
            end
            begin : consumer
                int budget;
                logic [15:0] v;
                budget = 0;
                while (got < 1000 && budget < 70000) begin
                    or_d = ($urandom_range(0, 3) != 0);
                    if (ov_d && or_d) begin
                        checks++;
                        if (expq.size() == 0) begin
                            errors++; $display("FAIL rand_duplicate: got bcd=%h with nothing pending", bcd_d);
                        end else begin
                            v = expq.pop_front();
                            if (bcd_d !== ref_bcd5(v) || of_d !== (v >= 100000)) begin
                                errors++; $display("FAIL rand_%0d: bcd=%h of=%b want %h 0", v, bcd_d, of_d, ref_bcd5(v));
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    budget++;
                end
                or_d = 1'b1;
            end
        join
        checks++;
        if (got != 1000 || sent != 1000 || expq.size() != 0) begin
            errors++; $display("FAIL rand_count: sent=%0d got=%0d pending=%0d want 1000 1000 0", sent, got, expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_main_255();
        test_digits2();
        test_legacy();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter that generalises the single-digit combinational converter to `W`-bit inputs and `DIGITS` decimal digits. It uses shift-add-3 (double dabble) with one bit per clock and valid/ready handshakes on both sides. It sits between binary datapath results and multi-digit display or formatting logic. A sticky `overflow` flag generalises the legacy `carry`: it is set when the input does not fit in `DIGITS` digits, and `bcd` then holds the value mod 10^DIGITS.

## Interface

**Parameters**
- `W`, default 8: input binary width; legal range is 4..32.
- `DIGITS`, default 3: number of BCD output digits; legal range is 1..10.

**Ports**
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `bin` is valid.
- `in_ready` out 1: converter idle and able to accept.
- `bin` in `W`: unsigned binary operand.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `bcd` out `4*DIGITS`: packed BCD, digit 0 (units) at bits [3:0].
- `overflow` out 1: `bin` ≥ 10^DIGITS.

## Operation

**States**
- IDLE: `in_ready`=1.
  - `in_valid`&&`in_ready` → capture `bin` into the shift register, clear the BCD accumulator and the sticky overflow, set the bit counter to `W`, go to SHIFT.
- SHIFT, each cycle:
  - Every digit ≥5 gets +3.
  - Then {bcd_acc, shift_reg} shifts left by 1.
  - The bit shifted out of the top digit is ORed into sticky overflow.
  - Counter decrements. When it reaches 0, go to DONE.
- DONE: `out_valid`=1.
  - `out_valid`&&`out_ready` → IDLE.

**Arithmetic**
- Invariant: bin = bcd value + 10^DIGITS × (count of shifted-out bits). The result is therefore bin mod 10^DIGITS, and `overflow` = (bin ≥ 10^DIGITS).
- Every output digit is always in 0..9.

**Outputs**
- `bcd` and `overflow` are registered.
- They stay stable while `out_valid`=1.
- They hold the last result after handshake completes, until the next DONE.
- They are not cleared by a new capture.

**Handshake rules**
- `in_valid` is ignored outside IDLE. No input is buffered.
- `out_ready` is ignored when `out_valid`=0.
- `out_ready` may be held high permanently. In that case DONE lasts exactly one cycle.

**Reset**
- Values while `rst` is high and on the cycle after: state IDLE, `out_valid`=0, `bcd`=0, `overflow`=0, counter=0.
- `in_ready`=0 while `rst` is high and 1 on the first cycle after.
- Reset mid-SHIFT or mid-DONE aborts the conversion. No `out_valid` is produced for it.

## Timing

- Capture edge is edge 0. SHIFT occupies edges 1..W. `out_valid` is high from the cycle after edge W.
- The result therefore appears W+1 cycles after capture.
- Minimum initiation interval is W+2 cycles (IDLE, W×SHIFT, DONE).
- `in_ready` falls the cycle after capture.
- `in_ready` rises the cycle after the output handshake.
- No combinational path from `in_valid` or `out_ready` to any output.

## Structure

- Package `bcd_pkg` contains:
  - `BCD_DIGIT_W`=4.
  - typedef `bcd_digit_t` (logic [3:0]).
  - enum `bcd_state_e` {IDLE, SHIFT, DONE}.
- Sub-module `bcd_digit_adj`: combinational, 4-bit in → 4-bit out, +3 when ≥5. Instantiated `DIGITS` times in a generate loop.
- Counter width is `$clog2(W+1)`.

## Test plan

- W=8, DIGITS=3, `bin`=255, `out_ready`=1:
  - `bcd`=12'h255, `overflow`=0.
  - `out_valid` high exactly 9 cycles after the capture edge, for 1 cycle.
- W=8, DIGITS=2, `bin`=123 → `bcd`=8'h23, `overflow`=1. With `bin`=99 → 8'h99, `overflow`=0.
- W=4, DIGITS=1, exhaustive 0..15:
  - 0..9 give `bcd`=`bin` with `overflow`=0.
  - 10..15 give `bcd`=`bin`−10 with `overflow`=1, matching the legacy converter's bcd/carry.
- Backpressure, W=8, DIGITS=3, `bin`=7:
  - Hold `out_ready`=0 for 5 cycles with `in_valid`=1 and `bin`=200.
  - Required: `bcd`=12'h007 stable, `in_ready`=0, 200 not captured.
  - Then raise `out_ready`: IDLE next cycle, 200 captured on the following edge.
- Reset asserted at SHIFT cycle 3 of a conversion:
  - `out_valid`=0, `bcd`=0, `overflow`=0 after reset.
  - `in_ready`=1 on the first post-reset cycle.
  - A new conversion of 42 yields 12'h042.
- Randomised W=16, DIGITS=5, 1000 values with random `in_valid`/`out_ready` gaps: every result matches a reference model of digits and overflow; no transfer lost or duplicated.
